// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back/write-allocate data cache; optional DCACHE_STATS_EN hit/miss counters
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t              state;
    logic                seen_busy;
    logic [LINES-1:0]    valid;
    logic [LINES-1:0]    dirty;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [127:0]        data [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            off;
    logic                  req;
    logic                  hit;
    logic [127:0]          line;
    logic [127:0]          merged;
    logic                  unused_addr;

    assign idx         = address[3+INDEX_BITS:4];
    assign tag         = address[31:4+INDEX_BITS];
    assign off         = address[3:2];
    assign req         = read | write;
    assign unused_addr = ^address[1:0];
    assign line        = data[idx];
    assign hit         = valid[idx] && (tags[idx] == tag);

    // Zero-wait hit path: stall only on a miss or while a block transfer is in flight
    always_comb begin
        busywait = (state != IDLE) || (req && !hit);
        readdata = '0;
        if (state == IDLE && read && !write && hit)
            readdata = line[{off, 5'b0} +: 32];
    end

    // Store word merged into the resident line
    always_comb begin
        merged = line;
        merged[{off, 5'b0} +: 32] = writedata;
    end

    // Controller FSM, line storage and registered memory-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            seen_busy     <= 1'b0;
            valid         <= '0;
            dirty         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (write) begin
                            data[idx]  <= merged;
                            dirty[idx] <= 1'b1;
                        end
                    end else if (req) begin
                        seen_busy <= 1'b0;
                        if (valid[idx] && dirty[idx]) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tags[idx], idx};
                            mem_writedata <= line;
                        end else begin
                            state       <= FETCH;
                            mem_read    <= 1'b1;
                            mem_address <= {tag, idx};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state         <= FETCH;
                        seen_busy     <= 1'b0;
                        mem_write     <= 1'b0;
                        mem_read      <= 1'b1;
                        mem_address   <= {tag, idx};
                        mem_writedata <= '0;
                    end
                end
                FETCH: begin
                    if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state       <= IDLE;
                        seen_busy   <= 1'b0;
                        mem_read    <= 1'b0;
                        mem_address <= '0;
                        data[idx]   <= mem_readdata;
                        tags[idx]   <= tag;
                        valid[idx]  <= 1'b1;
                        dirty[idx]  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating counters of requests resolved in IDLE as hit or miss
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && req) begin
            if (hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;

    logic         clk;
    logic         reset;
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] BLK_04 = 128'hC0000013_C0000012_C0000011_C0000010;
    localparam logic [127:0] BLK_0C = 128'hC0000033_C0000032_C0000031_C0000030;
    localparam logic [127:0] BLK_14 = 128'hC0000053_C0000052_C0000051_C0000050;

    data_cache #(.INDEX_BITS(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        read      = r;
        write     = w;
        address   = a;
        writedata = d;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Memory side: optionally hold busy low for pre cycles, then busy for lat cycles, then complete
    task automatic serve(input int pre, input int lat, input logic is_read, input logic [127:0] rdata);
        for (int i = 0; i < pre; i++) begin
            mem_busywait = 1'b0;
            step();
            check("op_held_before_busy", is_read ? mem_read : mem_write, 1'b1);
            check("stall_before_busy", busywait, 1'b1);
        end
        mem_busywait = 1'b1;
        for (int i = 0; i < lat; i++) step();
        check("op_held_while_busy", is_read ? mem_read : mem_write, 1'b1);
        if (is_read) mem_readdata = rdata;
        mem_busywait = 1'b0;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        read         = 1'b0;
        write        = 1'b0;
        address      = '0;
        writedata    = '0;
        mem_readdata = '0;
        mem_busywait = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 28'h0);
        check("rst_mem_writedata", mem_writedata, 128'h0);
        check("rst_busywait", busywait, 1'b0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_hit_count", hit_count, 16'h0);
        check("rst_miss_count", miss_count, 16'h0);

        // Cold read miss: straight to fetch, no writeback
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        check("miss40_busy", busywait, 1'b1);
        check("miss40_readdata", readdata, 32'h0);
        step();
        check("miss40_mem_read", mem_read, 1'b1);
        check("miss40_mem_write", mem_write, 1'b0);
        check("miss40_mem_address", mem_address, 28'h0000004);
        serve(0, 1, 1'b1, BLK_04);
        check("hit40_busy", busywait, 1'b0);
        check("hit40_readdata", readdata, 32'hC0000010);
        check("hit40_mem_read", mem_read, 1'b0);

        // Write hit then read back, both zero-wait
        drive(1'b0, 1'b1, 32'h0000_0044, 32'hABCD1234);
        check("wr44_busy", busywait, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        check("rd44_busy", busywait, 1'b0);
        check("rd44_readdata", readdata, 32'hABCD1234);

        // Conflict miss on a dirty line: writeback then fetch with delayed busy
        drive(1'b1, 1'b0, 32'h0000_00C4, 32'h0);
        check("missC4_busy", busywait, 1'b1);
        step();
        check("wb_mem_write", mem_write, 1'b1);
        check("wb_mem_read", mem_read, 1'b0);
        check("wb_mem_address", mem_address, 28'h0000004);
        check("wb_mem_writedata", mem_writedata, 128'hC0000013_C0000012_ABCD1234_C0000010);
`ifdef DCACHE_STATS_EN
        check("stats_hit_count", hit_count, 16'd3);
        check("stats_miss_count", miss_count, 16'd2);
`else
        check("stats_hit_count", hit_count, 16'd0);
        check("stats_miss_count", miss_count, 16'd0);
`endif
        serve(0, 2, 1'b0, 128'h0);
        check("fetchC_mem_read", mem_read, 1'b1);
        check("fetchC_mem_write", mem_write, 1'b0);
        check("fetchC_mem_address", mem_address, 28'h000000C);
        serve(3, 1, 1'b1, BLK_0C);
        check("hitC4_busy", busywait, 1'b0);
        check("hitC4_readdata", readdata, 32'hC0000031);

        // Reset in the middle of a fetch, coinciding with memory completion
        drive(1'b1, 1'b0, 32'h0000_0050, 32'h0);
        step();
        check("fetch50_mem_read", mem_read, 1'b1);
        check("fetch50_mem_address", mem_address, 28'h0000005);
        mem_busywait = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b1;
        mem_busywait = 1'b0;
        mem_readdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        check("midrst_mem_read", mem_read, 1'b0);
        check("midrst_mem_address", mem_address, 28'h0);
        check("midrst_busy", busywait, 1'b0);
        check("midrst_hit_count", hit_count, 16'h0);
        drive(1'b1, 1'b0, 32'h0000_00C4, 32'h0);
        check("postrst_C4_misses", busywait, 1'b1);
        step();
        check("postrst_mem_read", mem_read, 1'b1);
        check("postrst_mem_write", mem_write, 1'b0);
        check("postrst_mem_address", mem_address, 28'h000000C);
        serve(0, 1, 1'b1, BLK_0C);
        check("postrst_readdata", readdata, 32'hC0000031);

        // READ and WRITE together act as a write
        drive(1'b1, 1'b1, 32'h0000_00C4, 32'h5555AAAA);
        check("rw_busy", busywait, 1'b0);
        check("rw_readdata", readdata, 32'h0);
        drive(1'b1, 1'b0, 32'h0000_00C4, 32'h0);
        check("rw_readback", readdata, 32'h5555AAAA);
        drive(1'b0, 1'b0, 32'h0000_00C4, 32'h0);
        check("noreq_busy", busywait, 1'b0);
        check("noreq_readdata", readdata, 32'h0);
        check("noreq_mem_read", mem_read, 1'b0);
        check("noreq_mem_write", mem_write, 1'b0);

        // Evict the line dirtied by the combined request
        drive(1'b1, 1'b0, 32'h0000_0144, 32'h0);
        check("miss144_busy", busywait, 1'b1);
        step();
        check("wb2_mem_write", mem_write, 1'b1);
        check("wb2_mem_read", mem_read, 1'b0);
        check("wb2_mem_address", mem_address, 28'h000000C);
        check("wb2_mem_writedata", mem_writedata, 128'hC0000033_C0000032_5555AAAA_C0000030);
        serve(0, 1, 1'b0, 128'h0);
        check("fetch14_mem_read", mem_read, 1'b1);
        check("fetch14_mem_address", mem_address, 28'h0000014);
        serve(0, 1, 1'b1, BLK_14);
        check("hit144_busy", busywait, 1'b0);
        check("hit144_readdata", readdata, 32'hC0000051);
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter INDEX_BITS, default 3, SHALL set cache depth to 2**INDEX_BITS direct-mapped lines of 128 bits each.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 RESET  input  1  SHALL be the synchronous, active-high reset, sampled on rising CLK.
REQ-004 READ  input  1  SHALL carry the CPU load request (word).
REQ-005 WRITE  input  1  SHALL carry the CPU store request (word).
REQ-006 ADDRESS  input  32  SHALL carry the CPU byte address; [1:0] ignored, [3:2] word offset, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
REQ-007 WRITEDATA  input  32  SHALL carry the CPU store data.
REQ-008 READDATA  output  32  SHALL carry the CPU load data.
REQ-009 BUSYWAIT  output  1  SHALL stall the CPU while high.
REQ-010 MEM_READ / MEM_WRITE  output  1 each  SHALL carry the block read/write requests to data_memory.
REQ-011 MEM_ADDRESS  output  28  SHALL carry the block address {tag,index} to data_memory.
REQ-012 MEM_WRITEDATA  output  128  SHALL carry the victim block; MEM_READDATA input 128 SHALL carry the fetched block.
REQ-013 MEM_BUSYWAIT  input  1  SHALL carry the data_memory busy indication.

Function
REQ-014 Each line SHALL hold valid bit, dirty bit, tag (28-INDEX_BITS bits), 4 x 32-bit words; word 0 = bits [31:0].
REQ-015 FSM states SHALL be IDLE, WRITEBACK, FETCH; write-back, write-allocate policy.
REQ-016 Hit = valid AND stored tag == ADDRESS tag, evaluated combinationally in IDLE.
REQ-017 Read hit: READDATA SHALL equal the offset-selected word and BUSYWAIT SHALL be 0 in the same cycle (zero-wait); READDATA SHALL be 0 otherwise.
REQ-018 Write hit: BUSYWAIT SHALL be 0; word SHALL be written and dirty set at the next rising edge.
REQ-019 Miss in IDLE: BUSYWAIT SHALL be 1 combinationally; next edge SHALL enter WRITEBACK if victim valid AND dirty, else FETCH.
REQ-020 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim block; on completion SHALL go to FETCH.
REQ-021 FETCH: MEM_READ=1, MEM_ADDRESS={request tag,index}; on completion SHALL load MEM_READDATA, set valid=1, dirty=0, tag=request tag, go to IDLE.
REQ-022 Completion SHALL be the first rising edge in the state where MEM_BUSYWAIT=0 after at least one earlier edge in that state saw MEM_BUSYWAIT=1 (seen-busy flag, cleared on state entry).
REQ-023 BUSYWAIT SHALL be 1 throughout WRITEBACK and FETCH; after FETCH the retried request SHALL hit in IDLE with the REQ-017/018 timing.
REQ-024 MEM_READ and MEM_WRITE SHALL never be asserted together; both 0 in IDLE.
REQ-025 READ and WRITE both high SHALL be treated as WRITE; neither high SHALL leave BUSYWAIT 0 and state IDLE.
REQ-026 CPU inputs SHALL be held stable by the CPU while BUSYWAIT=1; cache does not latch them.

Reset
REQ-027 RESET SHALL clear every valid and dirty bit and force IDLE at the same edge, including mid-WRITEBACK/FETCH (transfer abandoned, no line update).
REQ-028 After reset: MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, BUSYWAIT=0 with no request, READDATA=0.
REQ-029 Reset SHALL take priority over any simultaneous request or memory completion.

Configuration
REQ-030 Macro DCACHE_STATS_EN defined: outputs HIT_COUNT[15:0] and MISS_COUNT[15:0] SHALL count requests resolved in IDLE as hit (once per completed access) and misses (once per IDLE->miss transition), saturating at 16'hFFFF, cleared by RESET.
REQ-031 DCACHE_STATS_EN undefined: HIT_COUNT and MISS_COUNT SHALL be tied to 0 and no counter logic synthesised.

Verification
REQ-032 Reset, READ ADDRESS=32'h0000_0040 -> BUSYWAIT=1, FETCH with MEM_ADDRESS=28'h0000004, no WRITEBACK; then READDATA=MEM_READDATA[31:0], BUSYWAIT=0, line valid.
REQ-033 WRITE 32'hABCD1234 to 32'h0000_0044 after REQ-032 -> BUSYWAIT stays 0, dirty set; READ 32'h0000_0044 same line -> 32'hABCD1234 zero-wait.
REQ-034 READ 32'h0000_00C4 (same index, tag differs, INDEX_BITS=3) -> WRITEBACK MEM_ADDRESS=28'h0000004 with word1=32'hABCD1234, then FETCH 28'h000000C.
REQ-035 RESET pulsed during FETCH -> IDLE next cycle, MEM_READ=0, all lines invalid; previously-hit address now misses.
REQ-036 MEM_BUSYWAIT held 0 for 3 cycles after MEM_READ rises before going high -> FSM stays in FETCH until MEM_BUSYWAIT falls (REQ-022).
REQ-037 DCACHE_STATS_EN defined, sequence REQ-032..034 -> HIT_COUNT=3, MISS_COUNT=2.
